// File: rtl/host_bridge.sv
// host_bridge: round-robin funnel of core requests into one host request FIFO,
// with per-core one-entry response buffers steered by host_resp_id.
module host_bridge #(
   parameter int NCORES = 2,
   parameter int DW = 64,
   parameter int DEPTH = 4,
   localparam int IDW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NCORES-1:0]    core_req_valid,
   output logic [NCORES-1:0]    core_req_ready,
   input  logic [NCORES*DW-1:0] core_req,
   output logic [NCORES-1:0]    core_resp_valid,
   input  logic [NCORES-1:0]    core_resp_ready,
   output logic [NCORES*DW-1:0] core_resp,
   output logic                 host_req_valid,
   input  logic                 host_req_ready,
   output logic [IDW-1:0]       host_req_id,
   output logic [DW-1:0]        host_req,
   input  logic                 host_resp_valid,
   output logic                 host_resp_ready,
   input  logic [IDW-1:0]       host_resp_id,
   input  logic [DW-1:0]        host_resp,
   output logic                 err_bad_id
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [IDW-1:0] LAST = IDW'(NCORES - 1);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [IDW-1:0] last_grant, gnt, c;
   logic gnt_any, full, push, pop, id_ok, resp_hs;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [IDW-1:0] mem_id [DEPTH];
   logic [DW-1:0] mem_data [DEPTH];
   logic [NCORES-1:0] rvalid, load;
   logic [DW-1:0] rdata [NCORES];
   // walk cores starting after last_grant; first valid one wins
   always_comb begin
      gnt = '0;
      gnt_any = 1'b0;
      c = last_grant;
      for (int k = 0; k < NCORES; k++) begin
         c = (c == LAST) ? '0 : c + 1'b1;
         if (core_req_valid[c] && !gnt_any) begin
            gnt = c;
            gnt_any = 1'b1;
         end
      end
   end
   assign full = count == FULL;
   assign push = rstn && gnt_any && !full;
   assign core_req_ready = push ? NCORES'(1) << gnt : '0;
   assign host_req_valid = rstn && count != '0;
   assign pop = host_req_valid && host_req_ready;
   assign host_req_id = mem_id[rd_ptr];
   assign host_req = mem_data[rd_ptr];
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         last_grant <= LAST;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            last_grant <= gnt;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr] <= gnt;
         mem_data[wr_ptr] <= core_req[gnt*DW +: DW];
      end
   end
   // out-of-range ids are always accepted so they can be dropped and flagged
   assign id_ok = {1'b0, host_resp_id} < (IDW+1)'(NCORES);
   assign host_resp_ready = rstn && (!id_ok || !rvalid[host_resp_id]);
   assign resp_hs = host_resp_valid && host_resp_ready;
   assign load = (resp_hs && id_ok) ? NCORES'(1) << host_resp_id : '0;
   assign core_resp_valid = rstn ? rvalid : '0;
   for (genvar i = 0; i < NCORES; i++) begin : g_resp
      assign core_resp[i*DW +: DW] = rdata[i];
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rvalid <= '0;
         err_bad_id <= 1'b0;
      end else begin
         rvalid <= (rvalid & ~(core_resp_valid & core_resp_ready)) | load;
         err_bad_id <= err_bad_id | (resp_hs && !id_ok);
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORES; i++)
         if (load[i]) rdata[i] <= host_resp;
   end
endmodule

// File: tb/tb_host_bridge.sv
// tb_host_bridge: scoreboard on the host request path plus a response-path vector table.
module tb_host_bridge;
   logic clk = 1'b0, rstn;
   logic [2:0] core_req_valid, core_req_ready, core_resp_valid, core_resp_ready;
   logic [47:0] core_req, core_resp;
   logic host_req_valid, host_req_ready, host_resp_valid, host_resp_ready, err_bad_id;
   logic [1:0] host_req_id, host_resp_id;
   logic [15:0] host_req, host_resp;
   int checks = 0, errors = 0;
   logic [17:0] exp_q[$];
   logic [17:0] e;

   typedef struct {
      logic hv; logic [1:0] hid; logic [15:0] hd; logic [2:0] crr;
      logic hrr; logic [2:0] crv; logic err; int core; logic [15:0] data;
   } vec_t;
   vec_t tbl[12];

   host_bridge #(.NCORES(3), .DW(16), .DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req(core_req),
      .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready), .core_resp(core_resp),
      .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
      .host_req_id(host_req_id), .host_req(host_req),
      .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
      .host_resp_id(host_resp_id), .host_resp(host_resp),
      .err_bad_id(err_bad_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // handshakes seen here complete on the next rising edge
   always @(negedge clk) begin
      if (!rstn) exp_q.delete();
      else begin
         if (host_req_valid && host_req_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected got=%h exp=none", {host_req_id, host_req});
            end else begin
               e = exp_q.pop_front();
               chk("sb_host_req", {host_req_id, host_req}, e);
            end
         end
         for (int i = 0; i < 3; i++)
            if (core_req_valid[i] && core_req_ready[i]) exp_q.push_back({2'(i), core_req[i*16 +: 16]});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 2'd1, 16'h55, 3'b000, 1'b1, 3'b010, 1'b0, 1, 16'h55};
      tbl[1]  = '{1'b1, 2'd1, 16'h66, 3'b000, 1'b0, 3'b010, 1'b0, 1, 16'h55};
      tbl[2]  = '{1'b1, 2'd1, 16'h66, 3'b000, 1'b0, 3'b010, 1'b0, 1, 16'h55};
      tbl[3]  = '{1'b1, 2'd1, 16'h66, 3'b010, 1'b0, 3'b000, 1'b0, 1, 16'h00};
      tbl[4]  = '{1'b1, 2'd1, 16'h66, 3'b000, 1'b1, 3'b010, 1'b0, 1, 16'h66};
      tbl[5]  = '{1'b1, 2'd0, 16'h77, 3'b000, 1'b1, 3'b011, 1'b0, 0, 16'h77};
      tbl[6]  = '{1'b1, 2'd3, 16'h99, 3'b000, 1'b1, 3'b011, 1'b1, 1, 16'h66};
      tbl[7]  = '{1'b0, 2'd2, 16'h00, 3'b011, 1'b1, 3'b000, 1'b1, 0, 16'h00};
      tbl[8]  = '{1'b1, 2'd3, 16'h12, 3'b000, 1'b1, 3'b000, 1'b1, 0, 16'h00};
      tbl[9]  = '{1'b1, 2'd2, 16'h22, 3'b000, 1'b1, 3'b100, 1'b1, 2, 16'h22};
      tbl[10] = '{1'b1, 2'd0, 16'h88, 3'b000, 1'b1, 3'b101, 1'b1, 0, 16'h88};
      tbl[11] = '{1'b0, 2'd0, 16'h00, 3'b100, 1'b0, 3'b001, 1'b1, 0, 16'h88};

      rstn = 1'b0;
      core_req_valid = 3'b111;
      core_req = '0;
      host_req_ready = 1'b1;
      core_resp_ready = '0;
      host_resp_valid = 1'b1;
      host_resp_id = '0;
      host_resp = '0;
      repeat (2) tick();
      chk("rst_core_req_ready", core_req_ready, 3'b000);
      chk("rst_host_req_valid", host_req_valid, 1'b0);
      chk("rst_core_resp_valid", core_resp_valid, 3'b000);
      chk("rst_host_resp_ready", host_resp_ready, 1'b0);
      rstn = 1'b1;
      core_req_valid = '0;
      host_resp_valid = 1'b0;
      host_req_ready = 1'b0;
      #1;
      chk("post_rst_host_req_valid", host_req_valid, 1'b0);
      chk("post_rst_core_resp_valid", core_resp_valid, 3'b000);
      chk("post_rst_err", err_bad_id, 1'b0);
      chk("post_rst_host_resp_ready", host_resp_ready, 1'b1);

      // two cores contending with the host always ready
      core_req = {16'h0, 16'h00B0, 16'h00A0};
      core_req_valid = 3'b011;
      host_req_ready = 1'b1;
      #1;
      chk("rr_first", core_req_ready, 3'b001);
      for (int n = 1; n <= 6; n++) begin
         tick();
         chk("rr_head_id", host_req_id, 64'((n - 1) % 2));
         chk("rr_head_data", host_req, (n % 2) ? 16'hA0 : 16'hB0);
         chk("rr_ready", core_req_ready, (n % 2) ? 3'b010 : 3'b001);
         if (n == 6) core_req_valid = '0;
      end
      tick();
      chk("rr_drained", host_req_valid, 1'b0);

      // fill with the host stalled, then one pop while full
      host_req_ready = 1'b0;
      core_req_valid = 3'b001;
      for (int k = 0; k < 5; k++) begin
         core_req[15:0] = 16'h101 + 16'(k);
         #1;
         chk("fill_ready", core_req_ready[0], k < 4);
         tick();
      end
      chk("full_head", host_req, 16'h101);
      host_req_ready = 1'b1;
      #1;
      chk("full_pop_no_push", core_req_ready[0], 1'b0);
      tick();
      host_req_ready = 1'b0;
      #1;
      chk("slot_freed", core_req_ready[0], 1'b1);
      chk("after_pop_head", host_req, 16'h102);
      tick();
      chk("full_again", core_req_ready[0], 1'b0);
      core_req_valid = '0;
      host_req_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("drain_valid", host_req_valid, j < 3);
      end
      host_req_ready = 1'b0;

      for (int r = 0; r < 12; r++) begin
         host_resp_valid = tbl[r].hv;
         host_resp_id = tbl[r].hid;
         host_resp = tbl[r].hd;
         core_resp_ready = tbl[r].crr;
         #1;
         chk($sformatf("tbl%0d_hrr", r), host_resp_ready, tbl[r].hrr);
         tick();
         chk($sformatf("tbl%0d_crv", r), core_resp_valid, tbl[r].crv);
         chk($sformatf("tbl%0d_err", r), err_bad_id, tbl[r].err);
         if (tbl[r].crv[tbl[r].core])
            chk($sformatf("tbl%0d_data", r), core_resp[tbl[r].core*16 +: 16], tbl[r].data);
      end
      host_resp_valid = 1'b0;
      core_resp_ready = '0;

      // queue three requests, then pulse reset with traffic present on every port
      core_req_valid = 3'b010;
      for (int k = 0; k < 3; k++) begin
         core_req[31:16] = 16'h201 + 16'(k);
         #1;
         chk("q_ready", core_req_ready, 3'b010);
         tick();
      end
      core_req_valid = '0;
      #1;
      chk("q_valid", host_req_valid, 1'b1);
      rstn = 1'b0;
      core_req = {16'h302, 16'h301, 16'h300};
      core_req_valid = 3'b111;
      host_req_ready = 1'b1;
      core_resp_ready = 3'b111;
      host_resp_valid = 1'b1;
      host_resp_id = 2'd1;
      #1;
      chk("rcyc_core_req_ready", core_req_ready, 3'b000);
      chk("rcyc_host_req_valid", host_req_valid, 1'b0);
      chk("rcyc_core_resp_valid", core_resp_valid, 3'b000);
      chk("rcyc_host_resp_ready", host_resp_ready, 1'b0);
      tick();
      rstn = 1'b1;
      host_req_ready = 1'b0;
      core_resp_ready = '0;
      host_resp_valid = 1'b0;
      #1;
      chk("rrel_host_req_valid", host_req_valid, 1'b0);
      chk("rrel_core_resp_valid", core_resp_valid, 3'b000);
      chk("rrel_err", err_bad_id, 1'b0);
      chk("rrel_grant", core_req_ready, 3'b001);
      tick();
      chk("rrel_head_id", host_req_id, 2'd0);
      chk("rrel_head_data", host_req, 16'h300);
      chk("rrel_next_grant", core_req_ready, 3'b010);
      core_req_valid = '0;
      host_req_ready = 1'b1;
      repeat (2) tick();
      chk("final_empty", host_req_valid, 1'b0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
